alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that lets two requesters share one
// external combinational ALU. A transaction is three states long:
// IDLE (grant), EXEC (result capture), DONE (acknowledge pulse).
module alu_arbiter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic [DATA_WIDTH-1:0] i_opA0,
   input  logic [DATA_WIDTH-1:0] i_opB0,
   input  logic [DATA_WIDTH-1:0] i_opA1,
   input  logic [DATA_WIDTH-1:0] i_opB1,
   input  logic [2:0]            i_aluOp0,
   input  logic [2:0]            i_aluOp1,
   input  logic [DATA_WIDTH-1:0] i_aluResult,
   output logic                  o_ack0,
   output logic                  o_ack1,
   output logic [DATA_WIDTH-1:0] o_result0,
   output logic [DATA_WIDTH-1:0] o_result1,
   output logic                  o_busy,
   output logic [DATA_WIDTH-1:0] o_aluOperand1,
   output logic [DATA_WIDTH-1:0] o_aluOperand2,
   output logic [2:0]            o_aluAluop
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_grantId;
   logic                  r_lastGrant;
   logic                  r_ack0;
   logic                  r_ack1;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_result0;
   logic [DATA_WIDTH-1:0] r_result1;
   logic [DATA_WIDTH-1:0] r_aluOperand1;
   logic [DATA_WIDTH-1:0] r_aluOperand2;
   logic [2:0]            r_aluAluop;

   logic                  w_anyReq;
   logic                  w_winner;
   logic [DATA_WIDTH-1:0] w_winOpA;
   logic [DATA_WIDTH-1:0] w_winOpB;
   logic [2:0]            w_winAluOp;

   // Pick the winner: a lone requester wins, a tie goes to whoever was not granted last.
   always_comb begin
      w_anyReq   = i_req0 | i_req1;
      w_winner   = (i_req0 & i_req1) ? ~r_lastGrant : i_req1;
      w_winOpA   = w_winner ? i_opA1   : i_opA0;
      w_winOpB   = w_winner ? i_opB1   : i_opB0;
      w_winAluOp = w_winner ? i_aluOp1 : i_aluOp0;
   end

   // Transaction sequencer: grant in IDLE, capture the ALU result in EXEC, pulse ACK in DONE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_grantId     <= 1'b0;
         r_lastGrant   <= 1'b1;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_busy        <= 1'b0;
         r_result0     <= '0;
         r_result1     <= '0;
         r_aluOperand1 <= '0;
         r_aluOperand2 <= '0;
         r_aluAluop    <= 3'b000;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_aluOperand1 <= w_winOpA;
                  r_aluOperand2 <= w_winOpB;
                  r_aluAluop    <= w_winAluOp;
                  r_grantId     <= w_winner;
                  r_lastGrant   <= w_winner;
                  r_busy        <= 1'b1;
                  r_state       <= EXEC;
               end
            end
            EXEC: begin
               if (r_grantId) begin
                  r_result1 <= i_aluResult;
               end else begin
                  r_result0 <= i_aluResult;
               end
               r_ack0  <= ~r_grantId;
               r_ack1  <= r_grantId;
               r_state <= DONE;
            end
            DONE: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_ack0        = r_ack0;
   assign o_ack1        = r_ack1;
   assign o_busy        = r_busy;
   assign o_result0     = r_result0;
   assign o_result1     = r_result1;
   assign o_aluOperand1 = r_aluOperand1;
   assign o_aluOperand2 = r_aluOperand2;
   assign o_aluAluop    = r_aluAluop;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives both requesters of alu_arbiter, models the shared
// ALU, and scores every ACK against a queue of expected results.
module tb_alu_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0;
   logic          req1;
   logic [DW-1:0] opA0;
   logic [DW-1:0] opB0;
   logic [DW-1:0] opA1;
   logic [DW-1:0] opB1;
   logic [2:0]    aluOp0;
   logic [2:0]    aluOp1;
   logic [DW-1:0] aluResult;
   logic          ack0;
   logic          ack1;
   logic          busy;
   logic [DW-1:0] result0;
   logic [DW-1:0] result1;
   logic [DW-1:0] aluOperand1;
   logic [DW-1:0] aluOperand2;
   logic [2:0]    aluAluop;

   typedef struct {
      logic          id;
      logic [DW-1:0] res;
   } expect_t;

   expect_t       sbQ[$];
   expect_t       monE;
   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] bA[3];
   logic [DW-1:0] bB[3];
   logic [2:0]    bOp[3];
   int            acks;
   int            cyc;
   int            lastAck;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Reference behaviour of the shared ALU; 1xx codes subtract.
   function automatic logic [DW-1:0] aluRef(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] op);
      case (op)
         3'b000:  aluRef = b;
         3'b001:  aluRef = a + b;
         3'b010:  aluRef = a & b;
         3'b011:  aluRef = a | b;
         default: aluRef = a - b;
      endcase
   endfunction

   assign aluResult = aluRef(aluOperand1, aluOperand2, aluAluop);

   alu_arbiter #(.DATA_WIDTH(DW)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_req0        (req0),
      .i_req1        (req1),
      .i_opA0        (opA0),
      .i_opB0        (opB0),
      .i_opA1        (opA1),
      .i_opB1        (opB1),
      .i_aluOp0      (aluOp0),
      .i_aluOp1      (aluOp1),
      .i_aluResult   (aluResult),
      .o_ack0        (ack0),
      .o_ack1        (ack1),
      .o_result0     (result0),
      .o_result1     (result1),
      .o_busy        (busy),
      .o_aluOperand1 (aluOperand1),
      .o_aluOperand2 (aluOperand2),
      .o_aluAluop    (aluAluop)
   );

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Scoreboard: every ACK pops the oldest expectation and checks who and what.
   always @(negedge clk) begin
      if (ack0 || ack1) begin
         checkOutput("ackOneHot", 32'(ack0 & ack1), 0);
         checkOutput("sbNotEmpty", 32'(sbQ.size() != 0), 1);
         if (sbQ.size() != 0) begin
            monE = sbQ.pop_front();
            checkOutput("ackId", 32'(ack1), 32'(monE.id));
            checkOutput("result", 32'(monE.id ? result1 : result0), 32'(monE.res));
         end
      end
   end

   // Run one transaction from an idle arbiter; disturb changes operands and drops REQ after the grant.
   task automatic applyStimulus(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [2:0] op, input logic [DW-1:0] expRes,
                                input bit disturb);
      int            n = 0;
      int            busyCnt = 0;
      bit            seen = 0;
      logic [DW-1:0] otherRes;
      otherRes = id ? result0 : result1;
      if (id) begin
         opA1 = a; opB1 = b; aluOp1 = op; req1 = 1'b1;
      end else begin
         opA0 = a; opB0 = b; aluOp0 = op; req0 = 1'b1;
      end
      sbQ.push_back('{id, expRes});
      while (!seen && n < 8) begin
         @(posedge clk); #1;
         n++;
         if (busy) busyCnt++;
         if (n == 1) begin
            checkOutput("aluOperand1", 32'(aluOperand1), 32'(a));
            checkOutput("aluOperand2", 32'(aluOperand2), 32'(b));
            checkOutput("aluAluop", 32'(aluAluop), 32'(op));
            if (disturb) begin
               if (id) begin
                  opA1 = 8'h7F; opB1 = 8'h55; aluOp1 = 3'b011; req1 = 1'b0;
               end else begin
                  opA0 = 8'h7F; opB0 = 8'h55; aluOp0 = 3'b011; req0 = 1'b0;
               end
            end
         end
         if ((id ? ack1 : ack0) === 1'b1) seen = 1;
      end
      checkOutput("ackLatency", n, 2);
      checkOutput("busyCycles", busyCnt, 2);
      if (id) req1 = 1'b0; else req0 = 1'b0;
      @(posedge clk); #1;
      checkOutput("ackPulse", 32'(ack0 | ack1), 0);
      checkOutput("busyIdle", 32'(busy), 0);
      checkOutput("otherResult", 32'(id ? result0 : result1), 32'(otherRes));
   endtask

   // Abort the whole run if something stalls beyond any reasonable length.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      opA0 = '0; opB0 = '0; opA1 = '0; opB1 = '0; aluOp0 = '0; aluOp1 = '0;
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("rstAck0", 32'(ack0), 0);
      checkOutput("rstAck1", 32'(ack1), 0);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstResult0", 32'(result0), 0);
      checkOutput("rstResult1", 32'(result1), 0);
      checkOutput("rstOperand1", 32'(aluOperand1), 0);
      checkOutput("rstOperand2", 32'(aluOperand2), 0);
      checkOutput("rstAluop", 32'(aluAluop), 0);
      reset = 1'b0;

      $display("[TB] single request on requester 0");
      applyStimulus(1'b0, 8'h05, 8'h04, 3'b001, 8'h09, 1'b0);

      $display("[TB] opcode coverage on requester 1");
      applyStimulus(1'b1, 8'hA0, 8'h0A, 3'b000, 8'h0A, 1'b0);
      applyStimulus(1'b1, 8'hA0, 8'h0A, 3'b010, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'hA0, 8'h0A, 3'b011, 8'hAA, 1'b0);
      applyStimulus(1'b1, 8'hF0, 8'h0A, 3'b010, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h33, 8'h11, 3'b101, 8'h22, 1'b0);

      $display("[TB] operand change and REQ drop after grant");
      applyStimulus(1'b0, 8'h01, 8'h02, 3'b001, 8'h03, 1'b1);

      $display("[TB] reset during EXEC");
      opA0 = 8'h05; opB0 = 8'h04; aluOp0 = 3'b001; req0 = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("abortAck0", 32'(ack0), 0);
      checkOutput("abortBusy", 32'(busy), 0);
      checkOutput("abortResult0", 32'(result0), 0);
      checkOutput("abortAluop", 32'(aluAluop), 0);
      applyStimulus(1'b0, 8'h05, 8'h04, 3'b001, 8'h09, 1'b0);

      $display("[TB] tie after reset");
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      opA0 = 8'h11; opB0 = 8'h22; aluOp0 = 3'b001;
      opA1 = 8'h0F; opB1 = 8'hF0; aluOp1 = 3'b011;
      sbQ.push_back('{1'b0, 8'h33});
      sbQ.push_back('{1'b1, 8'hFF});
      sbQ.push_back('{1'b0, 8'h33});
      req0 = 1'b1; req1 = 1'b1;
      acks = 0; cyc = 0;
      while (acks < 3 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
         if (ack0 || ack1) begin
            acks++;
            if (ack1) req1 = 1'b0;
            if (acks == 3) req0 = 1'b0;
         end
      end
      checkOutput("tieAcks", acks, 3);
      @(posedge clk); #1;

      $display("[TB] back-to-back on requester 1");
      for (int k = 0; k < 3; k++) begin
         bA[k]  = 8'($urandom_range(0, 255));
         bB[k]  = 8'($urandom_range(0, 255));
         bOp[k] = 3'($urandom_range(0, 3));
         sbQ.push_back('{1'b1, aluRef(bA[k], bB[k], bOp[k])});
      end
      opA1 = bA[0]; opB1 = bB[0]; aluOp1 = bOp[0]; req1 = 1'b1;
      acks = 0; cyc = 0; lastAck = 0;
      while (acks < 3 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
         if (ack1) begin
            if (acks > 0) checkOutput("b2bInterval", cyc - lastAck, 3);
            lastAck = cyc;
            acks++;
            if (acks < 3) begin
               opA1 = bA[acks]; opB1 = bB[acks]; aluOp1 = bOp[acks];
            end else begin
               req1 = 1'b0;
            end
         end
      end
      checkOutput("b2bAcks", acks, 3);
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("sbDrained", 32'(sbQ.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
